// File: rtl/cache_ctrl.sv
// cache_ctrl: sequences single CPU requests against an attached cache and a
// slow req/ack backing memory. Reads refill the cache on a miss; writes are
// write-through with write-allocate.
// Optional feature macro: CACHE_CTRL_STATS_EN adds saturating read hit/miss
// counters on outputs hit_count and miss_count.
module cache_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   output logic                  cache_we,
   output logic [ADDR_WIDTH-1:0] cache_addr,
   output logic [DATA_WIDTH-1:0] cache_din,
   input  logic [DATA_WIDTH-1:0] cache_dout,
   input  logic                  cache_hit,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [15:0]           hit_count,
   output logic [15:0]           miss_count
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_RD,
      FILL,
      MEM_WR,
      RESP
   } state_t;

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   fill_q, fill_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   // State and request/data registers; reset abandons any memory transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         fill_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fill_q  <= fill_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state and register update logic
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      fill_d  = fill_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               we_d    = cpu_we;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (we_q) begin
               state_d = MEM_WR;
            end else if (cache_hit) begin
               rdata_d = cache_dout;
               state_d = RESP;
            end else begin
               state_d = MEM_RD;
            end
         end
         MEM_RD: begin
            if (mem_ack) begin
               fill_d  = mem_rdata;
               state_d = FILL;
            end
         end
         FILL: begin
            rdata_d = fill_q;
            state_d = RESP;
         end
         MEM_WR: begin
            if (mem_ack) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore output decode; addresses and data come straight from the latches
   always_comb begin
      cpu_ready  = (state_q == RESP);
      cache_we   = ((state_q == LOOKUP) && we_q) || (state_q == FILL);
      cache_din  = (state_q == FILL) ? fill_q : wdata_q;
      cache_addr = addr_q;
      mem_req    = (state_q == MEM_RD) || (state_q == MEM_WR);
      mem_we     = (state_q == MEM_WR);
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      cpu_rdata  = rdata_q;
   end

`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;
   logic        rd_lookup;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Count read lookups only; writes never touch the counters
   always_comb begin
      rd_lookup  = (state_q == LOOKUP) && !we_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (rd_lookup && cache_hit)  hit_cnt_d  = sat_inc(hit_cnt_q);
      if (rd_lookup && !cache_hit) miss_cnt_d = sat_inc(miss_cnt_q);
   end

   // Statistics counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule
